// File: rtl/rr_stream_mux_pkg.sv
// Shared constants and helpers for the round-robin stream multiplexer.
package rr_stream_mux_pkg;

  localparam int unsigned MAX_CH     = 16;
  localparam int unsigned MAX_DATA_W = 64;

  // Index width for n channels, never narrower than one bit.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a registered last-grant pointer.
// RR_STREAM_MUX_LOCK_EN adds packet locking: the grant sticks until a beat with last transfers.
module rr_arbiter
  import rr_stream_mux_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned SelW   = sel_width(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] req_i,
  input  logic              enable_i,
  input  logic              advance_i,
  input  logic [SelW-1:0]   adv_idx_i,
`ifdef RR_STREAM_MUX_LOCK_EN
  input  logic              last_i,
  input  logic              lock_clr_i,
`endif
  output logic [NUM_CH-1:0] grant_o,
  output logic [SelW-1:0]   grant_idx_o
);

  logic [SelW-1:0] ptr_q, ptr_d;
  int unsigned     cand;
  logic            found;

`ifdef RR_STREAM_MUX_LOCK_EN
  logic lock_q, lock_d;

  // The locked channel is always the last granted one, so ptr_q doubles as the lock owner.
  always_comb begin
    lock_d = lock_q;
    if (lock_clr_i) begin
      lock_d = 1'b0;
    end else if (advance_i) begin
      lock_d = !last_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_q <= 1'b0;
    end else begin
      lock_q <= lock_d;
    end
  end
`endif

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    cand        = 0;
`ifdef RR_STREAM_MUX_LOCK_EN
    if (lock_q) begin
      if (enable_i && req_i[ptr_q]) begin
        grant_o[ptr_q] = 1'b1;
        grant_idx_o    = ptr_q;
      end
    end else
`endif
    if (enable_i) begin
      for (int unsigned k = 1; k <= NUM_CH; k++) begin
        cand = 32'(ptr_q) + k;
        if (cand >= NUM_CH) begin
          cand = cand - NUM_CH;
        end
        if (!found && req_i[cand]) begin
          found         = 1'b1;
          grant_o[cand] = 1'b1;
          grant_idx_o   = SelW'(cand);
        end
      end
    end
  end

  always_comb begin
    ptr_d = advance_i ? adv_idx_i : ptr_q;
  end

  // Reset to the top channel so channel 0 wins the first search.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= SelW'(NUM_CH - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/rr_stream_mux.sv
// N-channel valid/ready stream mux: round-robin or forced select into a registered output stage.
// Define RR_STREAM_MUX_LOCK_EN for packet-locked arbitration with in_last/out_last ports.
module rr_stream_mux
  import rr_stream_mux_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned SelW   = sel_width(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic [NUM_CH-1:0]        in_ready,
`ifdef RR_STREAM_MUX_LOCK_EN
  input  logic [NUM_CH-1:0]        in_last,
  output logic                     out_last,
`endif
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [SelW-1:0]          out_sel,
  input  logic                     out_ready,
  input  logic                     force_en,
  input  logic [SelW-1:0]          force_sel
);

  logic              load_ok, rr_enable, xfer;
  logic [NUM_CH-1:0] rr_grant, force_grant;
  logic [SelW-1:0]   rr_idx, grant_idx;
  logic [DATA_W-1:0] data_mux;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [SelW-1:0]   out_sel_q, out_sel_d;

`ifdef RR_STREAM_MUX_LOCK_EN
  logic last_mux, out_last_q, out_last_d;
`endif

  assign load_ok   = !rst && (!out_valid_q || out_ready);
  assign rr_enable = load_ok && !force_en;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .SelW   (SelW)
  ) u_arb (
    .clk         (clk),
    .rst         (rst),
    .req_i       (in_valid),
    .enable_i    (rr_enable),
    .advance_i   (xfer),
    .adv_idx_i   (grant_idx),
`ifdef RR_STREAM_MUX_LOCK_EN
    .last_i      (last_mux),
    .lock_clr_i  (force_en),
`endif
    .grant_o     (rr_grant),
    .grant_idx_o (rr_idx)
  );

  // Out-of-range force_sel matches no channel, so it naturally grants nothing.
  always_comb begin
    force_grant = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      force_grant[i] = load_ok && force_en && in_valid[i] && (force_sel == SelW'(i));
    end
    in_ready  = force_en ? force_grant : rr_grant;
    grant_idx = force_en ? force_sel : rr_idx;
    xfer      = |in_ready;
    data_mux  = '0;
`ifdef RR_STREAM_MUX_LOCK_EN
    last_mux  = 1'b0;
`endif
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (in_ready[i]) begin
        data_mux = data_mux | in_data[i*DATA_W +: DATA_W];
`ifdef RR_STREAM_MUX_LOCK_EN
        last_mux = last_mux | in_last[i];
`endif
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
`ifdef RR_STREAM_MUX_LOCK_EN
    out_last_d  = out_last_q;
`endif
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = data_mux;
      out_sel_d   = grant_idx;
`ifdef RR_STREAM_MUX_LOCK_EN
      out_last_d  = last_mux;
`endif
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
`ifdef RR_STREAM_MUX_LOCK_EN
      out_last_q  <= 1'b0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
`ifdef RR_STREAM_MUX_LOCK_EN
      out_last_q  <= out_last_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
`ifdef RR_STREAM_MUX_LOCK_EN
  assign out_last  = out_last_q;
`endif

endmodule
